// File: rtl/axi4_lite_rf_bridge_if.sv
// AXI4-Lite slave-side bus bundle for axi4_lite_rf_bridge.
// Handshake rule on every channel: a transfer happens on the rising clk edge where VALID and READY are both high;
// once VALID is raised, VALID and its payload stay stable until that edge, and READY may change freely.
interface axi4_lite_rf_bridge_if #(
    parameter int NMBROFDATABITS = 32,
    parameter int NMBROFADDRBITS = 7
);
    logic [NMBROFADDRBITS-1:0]   s_axi_awaddr;
    logic                        s_axi_awvalid;
    logic                        s_axi_awready;
    logic [NMBROFDATABITS-1:0]   s_axi_wdata;
    logic [NMBROFDATABITS/8-1:0] s_axi_wstrb;
    logic                        s_axi_wvalid;
    logic                        s_axi_wready;
    logic [1:0]                  s_axi_bresp;
    logic                        s_axi_bvalid;
    logic                        s_axi_bready;
    logic [NMBROFADDRBITS-1:0]   s_axi_araddr;
    logic                        s_axi_arvalid;
    logic                        s_axi_arready;
    logic [NMBROFDATABITS-1:0]   s_axi_rdata;
    logic [1:0]                  s_axi_rresp;
    logic                        s_axi_rvalid;
    logic                        s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/axi4_lite_rf_bridge.sv
// AXI4-Lite slave that turns one read or write at a time into single-cycle register-file strobes.
// Optional: define AXIL_ADDR_DECERR_EN to answer word addresses >= 16 with SLVERR and no strobe.
module axi4_lite_rf_bridge #(
    parameter int NMBROFDATABITS = 32,
    parameter int NMBROFADDRBITS = 7
) (
    input  logic                        clk,
    input  logic                        reset,
    axi4_lite_rf_bridge_if.slave        axi,
    output logic                        rf_wr_en,
    output logic [NMBROFADDRBITS-3:0]   rf_wr_addr,
    output logic [NMBROFDATABITS-1:0]   rf_wr_data,
    output logic                        rf_rd_en,
    output logic [NMBROFADDRBITS-3:0]   rf_rd_addr,
    input  logic [NMBROFDATABITS-1:0]   rf_rd_data,
    input  logic                        rf_data_valid,
    output logic [2:0]                  dbg_state
);
    localparam int WA = NMBROFADDRBITS - 2;
    localparam int DW = NMBROFDATABITS;
    localparam int SW = NMBROFDATABITS / 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_STROBE = 3'd1,
        WR_RESP   = 3'd2,
        RD_STROBE = 3'd3,
        RD_WAIT   = 3'd4,
        RD_RESP   = 3'd5
    } state_t;

    state_t          state, state_next;
    logic            active;
    logic            aw_full, w_full, ar_full;
    logic [WA-1:0]   aw_word, ar_word;
    logic [DW-1:0]   w_data;
    logic [SW-1:0]   w_strb;
    logic [WA-1:0]   wr_addr_q, rd_addr_q;
    logic [DW-1:0]   wr_data_q, rdata_q;
    logic            wr_err_q, rd_err_q;
    logic            last_rd;
    logic            aw_ready, w_ready, ar_ready;
    logic            wr_pend, rd_pend;
    logic            take_wr, take_rd;
    logic            wr_dec, rd_dec;
    logic            unused_low_bits;

    // READY is held low while in reset and for the first cycle after release.
    assign aw_ready = active & ~aw_full;
    assign w_ready  = active & ~w_full;
    assign ar_ready = active & ~ar_full;
    assign wr_pend  = aw_full & w_full;
    assign rd_pend  = ar_full;

`ifdef AXIL_ADDR_DECERR_EN
    assign wr_dec = (aw_word >= WA'(16));
    assign rd_dec = (ar_word >= WA'(16));
`else
    assign wr_dec = 1'b0;
    assign rd_dec = 1'b0;
`endif

    assign unused_low_bits = ^{axi.s_axi_awaddr[1:0], axi.s_axi_araddr[1:0]};

    always_comb begin
        state_next = state;
        take_wr    = 1'b0;
        take_rd    = 1'b0;
        rf_wr_en   = 1'b0;
        rf_rd_en   = 1'b0;
        case (state)
            IDLE: begin
                // Round-robin: a write wins a tie only if the read was served last.
                if (wr_pend && (!rd_pend || last_rd)) begin
                    take_wr    = 1'b1;
                    state_next = WR_STROBE;
                end else if (rd_pend) begin
                    take_rd    = 1'b1;
                    state_next = RD_STROBE;
                end
            end
            WR_STROBE: begin
                rf_wr_en   = ~wr_err_q;
                state_next = WR_RESP;
            end
            WR_RESP: begin
                if (axi.s_axi_bready) state_next = IDLE;
            end
            RD_STROBE: begin
                rf_rd_en   = ~rd_err_q;
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (rd_err_q || rf_data_valid) state_next = RD_RESP;
            end
            RD_RESP: begin
                if (axi.s_axi_rready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            active    <= 1'b0;
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            ar_full   <= 1'b0;
            aw_word   <= '0;
            ar_word   <= '0;
            w_data    <= '0;
            w_strb    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            rdata_q   <= '0;
            wr_err_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            last_rd   <= 1'b1;
        end else begin
            state  <= state_next;
            active <= 1'b1;

            if (axi.s_axi_awvalid && aw_ready) begin
                aw_full <= 1'b1;
                aw_word <= axi.s_axi_awaddr[NMBROFADDRBITS-1:2];
            end else if (take_wr) begin
                aw_full <= 1'b0;
            end

            if (axi.s_axi_wvalid && w_ready) begin
                w_full <= 1'b1;
                w_data <= axi.s_axi_wdata;
                w_strb <= axi.s_axi_wstrb;
            end else if (take_wr) begin
                w_full <= 1'b0;
            end

            if (axi.s_axi_arvalid && ar_ready) begin
                ar_full <= 1'b1;
                ar_word <= axi.s_axi_araddr[NMBROFADDRBITS-1:2];
            end else if (take_rd) begin
                ar_full <= 1'b0;
            end

            if (take_wr) begin
                wr_addr_q <= aw_word;
                wr_data_q <= w_data;
                wr_err_q  <= (w_strb != '1) | wr_dec;
                last_rd   <= 1'b0;
            end

            if (take_rd) begin
                rd_addr_q <= ar_word;
                rd_err_q  <= rd_dec;
                last_rd   <= 1'b1;
            end

            // The file drops its output after one cycle, so the return must be latched here.
            if (state == RD_WAIT) begin
                if (rd_err_q)           rdata_q <= '0;
                else if (rf_data_valid) rdata_q <= rf_rd_data;
            end
        end
    end

    assign axi.s_axi_awready = aw_ready;
    assign axi.s_axi_wready  = w_ready;
    assign axi.s_axi_arready = ar_ready;
    assign axi.s_axi_bvalid  = (state == WR_RESP);
    assign axi.s_axi_bresp   = wr_err_q ? 2'b10 : 2'b00;
    assign axi.s_axi_rvalid  = (state == RD_RESP);
    assign axi.s_axi_rresp   = rd_err_q ? 2'b10 : 2'b00;
    assign axi.s_axi_rdata   = rdata_q;

    assign rf_wr_addr = wr_addr_q;
    assign rf_wr_data = wr_data_q;
    assign rf_rd_addr = rd_addr_q;
    assign dbg_state  = state;
endmodule

// File: doc/axi4_lite_rf_bridge.md
Name:
axi4_lite_rf_bridge

Overview:
AXI4-Lite slave front-end sitting directly upstream of the register file. It converts one AXI4-Lite read or write at a time into single-cycle rd_en/wr_en strobes, captures the file's one-cycle rf_data_valid read return, and spaces strobes so the file's post-read busy cycle is never violated.

Parameters:
NMBROFDATABITS, 32, data width of the AXI bus and the register file.
NMBROFADDRBITS, 7, AXI byte-address width; the register-file word address is addr[NMBROFADDRBITS-1:2], giving 5 bits at the default.

Ports:
clk  in  1  single clock for all logic
reset  in  1  asynchronous, active-low reset (asserted = 0)
s_axi_awaddr  in  NMBROFADDRBITS  write byte address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address holding register empty
s_axi_wdata  in  NMBROFDATABITS  write data
s_axi_wstrb  in  NMBROFDATABITS/8  byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data holding register empty
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  master accepts write response
s_axi_araddr  in  NMBROFADDRBITS  read byte address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address holding register empty
s_axi_rdata  out  NMBROFDATABITS  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  master accepts read data
rf_wr_en  out  1  one-cycle write strobe to the register file
rf_wr_addr  out  NMBROFADDRBITS-2  register-file write word address
rf_wr_data  out  NMBROFDATABITS  register-file write data
rf_rd_en  out  1  one-cycle read strobe to the register file
rf_rd_addr  out  NMBROFADDRBITS-2  register-file read word address
rf_rd_data  in  NMBROFDATABITS  read data from the file, valid only with rf_data_valid
rf_data_valid  in  1  read return qualifier, high the cycle after rf_rd_en

Behaviour:
- Reset (reset=0): all outputs 0, holding registers empty, FSM in IDLE, priority set so that write is served first. Reset mid-transaction aborts it with no response, and any later rf_data_valid is ignored.
- AW, W and AR are each captured independently into 1-entry holding registers. The matching READY is high whenever its register is empty, so AW and W may arrive in either order or in the same cycle.
- FSM states: IDLE, WR_STROBE, WR_RESP, RD_STROBE, RD_WAIT, RD_RESP.
- IDLE: write is pending when AW and W are both full; read is pending when AR is full. If both are pending, the op not served last wins (round-robin). Holding registers are cleared on leaving IDLE.
- WR_STROBE: rf_wr_en=1 for exactly 1 cycle, unless the write is dropped (partial strobe or Optional Feature); next state is WR_RESP.
- WR_RESP: bvalid=1 with bresp held until bready, then IDLE. A full strobe gives OKAY (2'b00). Any wstrb other than all-ones gives SLVERR (2'b10) with no rf_wr_en.
- RD_STROBE: rf_rd_en=1 for 1 cycle, then RD_WAIT.
- RD_WAIT: on rf_data_valid, capture rf_rd_data into s_axi_rdata, then go to RD_RESP. The file clears its output the following cycle, so the capture is mandatory.
- RD_RESP: rvalid=1 with rresp=OKAY until rready, then IDLE.
- rf_wr_en and rf_rd_en are never high together. No strobe is issued within 1 cycle of a preceding rf_rd_en.
- Latency from the last address/data handshake edge (cycle 0): write gives rf_wr_en in cycle 2 and bvalid in cycle 3; read gives rf_rd_en in cycle 2, capture in cycle 3 and rvalid in cycle 4.
- VALID/data stay stable until accepted. A new AW/W/AR may be captured while a response is pending but is served only after returning to IDLE.

Optional Feature:
AXIL_ADDR_DECERR_EN. With it defined, a word address of 16 or more issues no rf strobe: a read returns rdata=0 with rresp=SLVERR, and a write returns bresp=SLVERR. Without it, such accesses go to the file unchanged with OKAY; the file ignores the write and reads return 0xFFFFFFFF.

Test Plan:
- Deassert reset, then write awaddr 0x08 with wdata 0xA5A5_1234 and wstrb 0xF -> rf_wr_en=1 for 1 cycle with rf_wr_addr=2; bvalid follows 1 cycle later with bresp=00.
- Read araddr 0x08 -> rf_rd_en at cycle 2, then rvalid with rdata=0xA5A5_1234 and rresp=00. Holding rready=0 for 5 cycles keeps rvalid and rdata stable.
- W presented 3 cycles before AW -> exactly one rf_wr_en, issued only after AW arrives.
- AW+W and AR held valid together continuously -> strobes alternate write, read, write. Check no rf_wr_en in the cycle after any rf_rd_en.
- wstrb=0x3 -> no rf_wr_en and bresp=SLVERR. Read of 0x40 -> rdata=0xFFFFFFFF/OKAY without the macro, rdata=0/SLVERR with AXIL_ADDR_DECERR_EN.
- Assert reset during RD_WAIT -> rvalid, bvalid and ready outputs go 0 immediately; a subsequent write completes normally.
